// File: rtl/ncca_err_monitor.sv
// Error-statistics monitor for the 8x8 approximate multiplier: counts mismatches and
// accumulates/maximises error distance over N_SAMPLES samples. Optional NCCA_BIAS_EN adds signed bias sum.
module ncca_err_monitor #(
    parameter int N_SAMPLES = 256,
    parameter int ACC_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    input  logic [15:0]       prod_apx,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [ACC_W-1:0]  sum_ed,
    output logic [15:0]       max_ed
`ifdef NCCA_BIAS_EN
    ,
    output logic signed [ACC_W:0] sum_bias
`endif
);

    localparam logic [15:0] N_LAST = 16'(N_SAMPLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state_reg, state_next;
    logic [15:0] cnt_reg;
    logic        accept;
    logic        clear;

    // stage 0: captured sample
    logic        s0_vld_reg;
    logic [7:0]  s0_a_reg, s0_b_reg;
    logic [15:0] s0_p_reg;
    // stage 1: error distance
    logic        s1_vld_reg;
    logic        s1_neq_reg;
    logic [15:0] s1_ed_reg;
    // stage 2: accumulators
    logic [15:0]      err_cnt_reg;
    logic [ACC_W-1:0] sum_ed_reg;
    logic [15:0]      max_ed_reg;

    logic [15:0]        exact;
    logic signed [16:0] diff;
    logic [15:0]        ed_next;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   sum_next;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt_reg == N_LAST) state_next = S_DRAIN;
            S_DRAIN: if (!s0_vld_reg && !s1_vld_reg) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == S_RUN) && (cnt_reg != N_LAST);
        busy     = (state_reg == S_RUN) || (state_reg == S_DRAIN);
        done     = (state_reg == S_DONE);
    end

    assign accept = in_valid && in_ready;
    assign clear  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    // ---------------- datapath ----------------
    always_comb begin
        exact    = 16'(s0_a_reg) * 16'(s0_b_reg);
        diff     = $signed({1'b0, exact}) - $signed({1'b0, s0_p_reg});
        ed_next  = diff[16] ? 16'(-diff) : diff[15:0];
        sum_wide = {1'b0, sum_ed_reg} + {{(ACC_W-15){1'b0}}, s1_ed_reg};
        // an overflow carry pins the sum at all-ones, so it sticks once saturated
        sum_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg     <= '0;
            s0_vld_reg  <= 1'b0;
            s0_a_reg    <= '0;
            s0_b_reg    <= '0;
            s0_p_reg    <= '0;
            s1_vld_reg  <= 1'b0;
            s1_neq_reg  <= 1'b0;
            s1_ed_reg   <= '0;
            err_cnt_reg <= '0;
            sum_ed_reg  <= '0;
            max_ed_reg  <= '0;
        end else begin
            if (accept) cnt_reg <= cnt_reg + 16'd1;
            s0_vld_reg <= accept;
            if (accept) begin
                s0_a_reg <= a;
                s0_b_reg <= b;
                s0_p_reg <= prod_apx;
            end
            s1_vld_reg <= s0_vld_reg;
            s1_ed_reg  <= ed_next;
            s1_neq_reg <= (ed_next != 16'd0);
            if (s1_vld_reg) begin
                err_cnt_reg <= err_cnt_reg + {15'd0, s1_neq_reg};
                sum_ed_reg  <= sum_next;
                if (s1_ed_reg > max_ed_reg) max_ed_reg <= s1_ed_reg;
            end
        end
    end

    assign err_cnt = err_cnt_reg;
    assign sum_ed  = sum_ed_reg;
    assign max_ed  = max_ed_reg;

`ifdef NCCA_BIAS_EN
    logic signed [16:0]    s1_bias_reg;
    logic signed [ACC_W:0] sum_bias_reg;
    logic [ACC_W+1:0]      bias_wide;
    logic [ACC_W:0]        bias_next;

    always_comb begin
        bias_wide = {sum_bias_reg[ACC_W], sum_bias_reg}
                  + {{(ACC_W-15){s1_bias_reg[16]}}, s1_bias_reg};
        if (bias_wide[ACC_W+1] != bias_wide[ACC_W])
            bias_next = bias_wide[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
        else
            bias_next = bias_wide[ACC_W:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_bias_reg  <= '0;
            sum_bias_reg <= '0;
        end else begin
            s1_bias_reg <= -diff;
            if (s1_vld_reg) sum_bias_reg <= $signed(bias_next);
        end
    end

    assign sum_bias = sum_bias_reg;
`endif

endmodule

// File: tb/tb_ncca_err_monitor.sv
// Directed bench for ncca_err_monitor: three instances (N=4, N=3, and N=3 with ACC_W=16)
// share the sample bus and are started one at a time.
module tb_ncca_err_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [15:0] prod_apx = '0;
    logic start4 = 1'b0, start3 = 1'b0, start_s = 1'b0;

    logic in_ready4, busy4, done4;
    logic [15:0] err4, max4;
    logic [31:0] sum4;
    logic in_ready3, busy3, done3;
    logic [15:0] err3, max3;
    logic [31:0] sum3;
    logic in_ready_s, busy_s, done_s;
    logic [15:0] err_s, max_s, sum_s;
`ifdef NCCA_BIAS_EN
    logic signed [32:0] bias4, bias3;
    logic signed [16:0] bias_s;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int acc3 = 0;
    int edges;

    always #5 clk = ~clk;

    ncca_err_monitor #(.N_SAMPLES(4), .ACC_W(32)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .prod_apx(prod_apx), .busy(busy4), .done(done4),
        .err_cnt(err4), .sum_ed(sum4), .max_ed(max4)
`ifdef NCCA_BIAS_EN
        , .sum_bias(bias4)
`endif
    );

    ncca_err_monitor #(.N_SAMPLES(3), .ACC_W(32)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .in_valid(in_valid), .in_ready(in_ready3),
        .a(a), .b(b), .prod_apx(prod_apx), .busy(busy3), .done(done3),
        .err_cnt(err3), .sum_ed(sum3), .max_ed(max3)
`ifdef NCCA_BIAS_EN
        , .sum_bias(bias3)
`endif
    );

    ncca_err_monitor #(.N_SAMPLES(3), .ACC_W(16)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .prod_apx(prod_apx), .busy(busy_s), .done(done_s),
        .err_cnt(err_s), .sum_ed(sum_s), .max_ed(max_s)
`ifdef NCCA_BIAS_EN
        , .sum_bias(bias_s)
`endif
    );

    // acceptances of dut3, sampled mid-cycle where handshake signals are settled
    always @(negedge clk) if (in_valid && in_ready3) acc3++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [15:0] pp);
        in_valid = v;
        a        = aa;
        b        = bb;
        prod_apx = pp;
        tick();
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            4:       return done4;
            3:       return done3;
            default: return done_s;
        endcase
    endfunction

    task automatic wait_done(input int sel, output int n);
        n = 0;
        while (!done_of(sel) && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        // reset and idle with in_valid asserted but no start
        rst = 1'b1;
        in_valid = 1'b1;
        a = 8'd3; b = 8'd3; prod_apx = 16'd1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("idle_in_ready", in_ready4, 0);
        check("idle_busy", busy4, 0);
        check("idle_done", done4, 0);
        check("idle_err_cnt", err4, 0);
        check("idle_sum_ed", sum4, 0);
        check("idle_max_ed", max4, 0);

        // exact run, N=4
        in_valid = 1'b0;
        start4 = 1'b1; tick(); start4 = 1'b0;
        check("exact_in_ready_after_start", in_ready4, 1);
        check("exact_busy", busy4, 1);
        drive(1, 8'd3, 8'd5, 16'd15);
        drive(1, 8'd255, 8'd255, 16'd65025);
        drive(1, 8'd0, 8'd9, 16'd0);
        drive(1, 8'd16, 8'd16, 16'd256);
        check("exact_in_ready_drop", in_ready4, 0);
        in_valid = 1'b0;
        wait_done(4, edges);
        check("exact_done_latency", edges, 3);
        check("exact_err_cnt", err4, 0);
        check("exact_sum_ed", sum4, 0);
        check("exact_max_ed", max4, 0);
        check("exact_busy_done", busy4, 0);

        // error run with gaps, N=3
        acc3 = 0;
        start3 = 1'b1; tick(); start3 = 1'b0;
        drive(1, 8'd10, 8'd10, 16'd96);
        check("err_lat_t1", sum3, 0);
        drive(0, 8'd0, 8'd0, 16'd0);
        check("err_lat_t2_before", sum3, 0);
        drive(1, 8'd255, 8'd255, 16'd65535);
        check("err_lat_t2_sum", sum3, 4);
        check("err_lat_t2_cnt", err3, 1);
        drive(1, 8'd7, 8'd7, 16'd49);
        check("err_in_ready_drop", in_ready3, 0);
        drive(1, 8'd255, 8'd255, 16'd0);
        check("err_partial_sum", sum3, 514);
        in_valid = 1'b0;
        wait_done(3, edges);
        check("err_done_after_last", edges, 2);
        check("err_accept_count", acc3, 3);
        check("err_err_cnt", err3, 2);
        check("err_sum_ed", sum3, 514);
        check("err_max_ed", max3, 510);
`ifdef NCCA_BIAS_EN
        check("err_sum_bias", 64'(bias3), 64'(506));
`endif
        check("other_dut_untouched", sum4, 0);

        // restart from DONE
        start3 = 1'b1; tick(); start3 = 1'b0;
        check("restart_err_cleared", err3, 0);
        check("restart_sum_cleared", sum3, 0);
        check("restart_max_cleared", max3, 0);
        check("restart_done_low", done3, 0);
        drive(1, 8'd2, 8'd3, 16'd6);
        drive(1, 8'd4, 8'd4, 16'd20);
        drive(1, 8'd1, 8'd1, 16'd0);
        in_valid = 1'b0;
        wait_done(3, edges);
        check("restart_done_latency", edges, 3);
        check("restart_err_cnt", err3, 2);
        check("restart_sum_ed", sum3, 5);
        check("restart_max_ed", max3, 4);
`ifdef NCCA_BIAS_EN
        check("restart_sum_bias", 64'(bias3), 64'(3));
`endif

        // abort by reset after 2 of 4 samples
        start4 = 1'b1; tick(); start4 = 1'b0;
        drive(1, 8'd255, 8'd255, 16'd65535);
        drive(1, 8'd255, 8'd255, 16'd65535);
        rst = 1'b1;
        drive(1, 8'd255, 8'd255, 16'd65535);
        check("abort_in_ready", in_ready4, 0);
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_err_cnt", err4, 0);
        check("abort_sum_ed", sum4, 0);
        check("abort_max_ed", max4, 0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("abort_flushed_sum", sum4, 0);
        check("abort_idle_ready", in_ready4, 0);
        in_valid = 1'b0;
        start4 = 1'b1; tick(); start4 = 1'b0;
        drive(1, 8'd1, 8'd1, 16'd1);
        drive(1, 8'd2, 8'd2, 16'd4);
        drive(1, 8'd3, 8'd3, 16'd9);
        drive(1, 8'd4, 8'd4, 16'd17);
        in_valid = 1'b0;
        wait_done(4, edges);
        check("abort_rerun_done_latency", edges, 3);
        check("abort_rerun_err_cnt", err4, 1);
        check("abort_rerun_sum_ed", sum4, 1);
        check("abort_rerun_max_ed", max4, 1);
`ifdef NCCA_BIAS_EN
        check("abort_rerun_sum_bias", 64'(bias4), 64'(1));
`endif

        // saturation, ACC_W=16
        start_s = 1'b1; tick(); start_s = 1'b0;
        drive(1, 8'd255, 8'd255, 16'd0);
        drive(1, 8'd255, 8'd255, 16'd0);
        drive(1, 8'd0, 8'd0, 16'd1);
        check("sat_first", sum_s, 65025);
        in_valid = 1'b0;
        tick();
        check("sat_second", sum_s, 65535);
        tick();
        check("sat_sticks", sum_s, 65535);
        wait_done(5, edges);
        check("sat_done_latency", edges, 1);
        check("sat_err_cnt", err_s, 3);
        check("sat_max_ed", max_s, 65025);
        check("sat_final_sum", sum_s, 65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ncca_err_monitor.md
# ncca_err_monitor

Sequential error-metric stage that sits directly downstream of the 8x8 approximate multiplier. Each accepted sample carries the operands `a`, `b` and the multiplier's `prod8` output. The block computes the exact product internally and accumulates error statistics over a fixed-size run. These statistics are error count, sum of error distance, and maximum error distance. The results characterise the approximate multiplier in hardware without a host-side golden model.

## Interface
- `N_SAMPLES`, 256 — number of samples per run; valid range 1..65535.
- `ACC_W`, 32 — width of the error-distance accumulator; minimum 16.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `start`  in  1  — begins a run. Sampled only in IDLE or DONE.
- `in_valid`  in  1  — sample present on `a`, `b`, `prod_apx`.
- `in_ready`  out  1  — block accepts a sample this cycle.
- `a`  in  8  — multiplicand fed to the multiplier.
- `b`  in  8  — multiplier operand fed to the multiplier.
- `prod_apx`  in  16  — approximate product (`prod8`) for the same `a`, `b`.
- `busy`  out  1  — high in RUN and DRAIN.
- `done`  out  1  — high in DONE, held until `start` or `rst`.
- `err_cnt`  out  16  — count of samples with `prod_apx != a*b`.
- `sum_ed`  out  ACC_W  — Σ|a*b − prod_apx|, saturating.
- `max_ed`  out  16  — max |a*b − prod_apx| over the run.

## Operation
- States: IDLE → RUN → DRAIN → DONE.
  - IDLE goes to RUN on `start`.
  - RUN goes to DRAIN when accepted-sample count reaches `N_SAMPLES`.
  - DRAIN goes to DONE when the pipeline is empty.
  - DONE goes to RUN on `start`.
- Entering RUN from IDLE or DONE clears `err_cnt`, `sum_ed`, `max_ed`, the sample counter and the pipeline.
- `in_ready` = 1 only in RUN. A sample is accepted on a cycle where `in_valid && in_ready`.
- Stage 1 registers the sample:
  - exact = a*b, unsigned 16-bit, max 65025;
  - ed = |exact − prod_apx|, computed as 17-bit signed difference then magnitude, 16-bit result;
  - neq = (ed != 0).
- Stage 2 updates the accumulators:
  - `err_cnt` += neq;
  - `sum_ed` += ed, saturating at 2^ACC_W − 1 and sticking there;
  - `max_ed` = max(`max_ed`, ed).
- `prod_apx` values above 65025 are legal inputs; the error distance is still computed as the true magnitude.
- `start` while in RUN or DRAIN is ignored.
- `in_valid` outside RUN is ignored, with no side effects.
- Statistics outputs remain visible in IDLE (after reset they read zero) and in DONE.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `err_cnt`=0, `sum_ed`=0, `max_ed`=0; state=IDLE.
- `start` at edge k puts the block in RUN from cycle k+1, so `in_ready`=1 from cycle k+1.
- Accumulator latency: a sample accepted at edge t is reflected in the outputs after edge t+2.
- Throughput is one sample per cycle. Gaps in `in_valid` are tolerated.
- `in_ready` drops in the cycle after the `N_SAMPLES`-th acceptance; no extra sample is ever accepted.
- DRAIN lasts exactly 2 cycles. `done` rises at edge t_last+3, where t_last is the final acceptance edge.
- `rst` asserted mid-run aborts immediately. All outputs return to reset values at the next edge, and in-flight samples are discarded.
- Simultaneous `rst` and `start`: `rst` wins.

## Configuration
- `NCCA_BIAS_EN` defined:
  - adds output `sum_bias`  out  ACC_W+1, signed, equal to Σ(prod_apx − exact);
  - `sum_bias` saturates at the signed min and max of its width;
  - cleared on run start and on reset; same 2-cycle latency as `sum_ed`.
- `NCCA_BIAS_EN` undefined: port and logic are absent; all other behaviour is identical.

## Test plan
- Reset/idle: hold `rst` 2 cycles, then drive `in_valid`=1 without `start` → all outputs 0, `in_ready`=0, `done`=0.
- Exact run, `N_SAMPLES`=4: samples (3,5,15), (255,255,65025), (0,9,0), (16,16,256) → `done`=1, `err_cnt`=0, `sum_ed`=0, `max_ed`=0.
- Error run, `N_SAMPLES`=3: samples (10,10,96), (255,255,65535), (7,7,49) → `err_cnt`=2, `sum_ed`=514, `max_ed`=510. With `NCCA_BIAS_EN`: `sum_bias`=+506.
- Handshake:
  - `in_valid` toggling 1,0,1,1 with `N_SAMPLES`=3 → exactly 3 acceptances;
  - `in_ready` low from the cycle after the 3rd;
  - `done` rises 3 edges after the last acceptance.
- Restart and abort:
  - `start` in DONE → stats cleared, new run proceeds;
  - `rst` asserted after 2 of 4 samples → all outputs 0 next cycle, state IDLE, later `start` gives clean results.
- Saturation, `ACC_W`=16: two samples with ed=65025 → `sum_ed`=65535 and it stays there.
